fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Round-robin arbiter that shares the single `fpu` instance between NUM_REQ requesters.
- Each requester presents operands and an op select through a valid/ready handshake.
- The arbiter drives the fpu, waits the fpu's result latency, captures `data_out`/`status_out` and returns them to the granted requester as a one-cycle response pulse.
- Sits between the requesting datapaths and the `fpu`; one operation is in flight at a time.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- FPU_LAT, 1: clock edges from fpu operand change until fpu `data_out`/`status_out` are valid, >=1.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*32  packed operand A; requester i at [32*i+31:32*i].
- req_b  in  NUM_REQ*32  packed operand B, same packing as req_a.
- req_sel  in  NUM_REQ  per-requester op select (0 add, 1 sub).
- resp_valid  out  NUM_REQ  one-hot, one-cycle result strobe.
- resp_data  out  32  result, shared by all requesters, qualified by resp_valid.
- resp_status  out  4  fpu status flags captured with resp_data.
- fpu_op_a  out  32  to fpu `op_a_in`.
- fpu_op_b  out  32  to fpu `op_b_in`.
- fpu_op_sel  out  1  to fpu `op_sel`.
- fpu_data  in  32  from fpu `data_out`.
- fpu_status  in  4  from fpu `status_out`.
- busy  out  1  high while an operation is in flight (state WAIT).
- ops_done  out  CNT_W  count of completed operations, wraps.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, cnt=0, last_grant=NUM_REQ-1.
- fpu_op_a/fpu_op_b=0, fpu_op_sel=0.
- resp_valid=0, resp_data=0, resp_status=0, ops_done=0, busy=0.
- Reset asserted mid-operation aborts it: no resp_valid is produced and the request is lost.

State IDLE:
- If any req_valid is high, grant g = first requester with valid set, searching upward from (last_grant+1) mod NUM_REQ and wrapping.
- req_ready[g]=1 combinationally in the same cycle; every other ready bit is 0.
- At that edge: register req_a[g], req_b[g], req_sel[g] into fpu_op_a/b/sel; cur_grant=g; cnt=FPU_LAT-1; go to WAIT.
- With no valid: req_ready=0 and the state is held.

State WAIT:
- busy=1, req_ready=0.
- If cnt!=0, decrement it.
- If cnt==0, at that edge:
  - resp_data<=fpu_data, resp_status<=fpu_status.
  - resp_valid<=onehot(cur_grant).
  - last_grant<=cur_grant.
  - ops_done<=ops_done+1, wrapping at 2^CNT_W.
  - Go to IDLE.

Response and timing:
- resp_valid is high for exactly one cycle. resp_data/resp_status hold their value until the next capture.
- The cycle in which resp_valid is high is an IDLE cycle, so a new request can be accepted in that same cycle.
- Latency: accept in cycle 0, fpu operands stable from cycle 1, resp_valid in cycle FPU_LAT+1.
- Throughput: one operation per FPU_LAT+1 cycles.
- fpu_op_* hold their last value between operations.

Requester protocol:
- req_valid and its operands must stay stable until req_ready.
- The arbiter does not check for a dropped req_valid.
- resp has no backpressure; requesters must take it in the strobe cycle.

Fairness:
- A continuously requesting requester is served within NUM_REQ grants.

Test Plan:
- Single requester, NUM_REQ=4, FPU_LAT=1: req 0 with a=b=0x3F000000, sel=0, accepted in cycle 0.
  - Required: fpu_op_a=0x3F000000 in cycle 1; resp_valid=4'b0001 in cycle 2.
  - Required: resp_data and resp_status equal the fpu's outputs sampled at the end of cycle 1.
  - Required: ops_done=1.
- All four valid continuously, each with distinct operands.
  - Required: grants in order 0,1,2,3,0; responses one-hot in the same order.
  - Required: each resp_data matches that requester's fpu result; exactly one ready per accept.
- Back-to-back: req 2 still valid when resp_valid=4'b0100 fires.
  - Required: req_ready[2]=1 in the same cycle as the strobe; second resp_valid exactly FPU_LAT+1 cycles later.
- FPU_LAT=3: sub with a=b=0x3F800000.
  - Required: busy high for 3 cycles; resp_valid 4 cycles after accept; resp_data equals fpu zero result.
- Reset pulse (rst=0) during WAIT.
  - Required: outputs return to reset values immediately; no resp_valid; ops_done=0.
  - Required: after release, requester 0 has highest priority.
- ops_done wrap with CNT_W=2.
  - Required: after 5 completed operations ops_done=1.

Source files
------------

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Purpose  : Round-robin sharing of one fpu among NUM_REQ valid/ready requesters.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sel,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_data,
  output logic [3:0]            resp_status,
  output logic [31:0]           fpu_op_a,
  output logic [31:0]           fpu_op_b,
  output logic                  fpu_op_sel,
  input  logic [31:0]           fpu_data,
  input  logic [3:0]            fpu_status,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(FPU_LAT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cur_grant;
  logic [LAT_W-1:0] cnt;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_op;

  // Rotating priority: the search starts just after the last requester served.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_grant) + 1 + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      idx = IDX_W'(cand);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_idx) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_sel[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_grant  <= LAST_IDX;
      cur_grant   <= '0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      fpu_op_sel  <= 1'b0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_status <= '0;
      ops_done    <= '0;
      busy        <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            fpu_op_a   <= sel_a;
            fpu_op_b   <= sel_b;
            fpu_op_sel <= sel_op;
            cur_grant  <= grant_idx;
            cnt        <= CNT_INIT;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            // The strobe cycle is IDLE again, so a new grant can overlap it.
            resp_data             <= fpu_data;
            resp_status           <= fpu_status;
            resp_valid[cur_grant] <= 1'b1;
            last_grant            <= cur_grant;
            ops_done              <= ops_done + CNT_W'(1);
            busy                  <= 1'b0;
            state                 <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Purpose  : Scoreboard bench for fpu_arbiter in two configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;

  typedef struct {
    int          due;
    int          grant;
    logic [31:0] data;
    logic [3:0]  status;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Integer stand-in for the fpu: {status, data}
  function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sel);
    logic [31:0] r;
    r = sel ? (a - b) : (a + b);
    return {(r == 32'd0), sel, a[31], b[31], r};
  endfunction

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int N   = (c == 0) ? 4 : 3;
    localparam int LAT = (c == 0) ? 1 : 3;
    localparam int CW  = (c == 0) ? 16 : 2;

    logic              rst;
    logic [N-1:0]      req_valid, req_ready, req_sel, resp_valid;
    logic [N*32-1:0]   req_a, req_b;
    logic [31:0]       resp_data, fpu_op_a, fpu_op_b, fpu_data;
    logic [3:0]        resp_status, fpu_status;
    logic              fpu_op_sel, busy;
    logic [CW-1:0]     ops_done;
    logic [35:0]       fpu_now;
    exp_t              sb[$];
    int                model_done;
    logic [31:0]       last_data;
    logic [3:0]        last_status;
    logic              fin = 1'b0;

    fpu_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .resp_valid(resp_valid),
      .resp_data(resp_data), .resp_status(resp_status), .fpu_op_a(fpu_op_a),
      .fpu_op_b(fpu_op_b), .fpu_op_sel(fpu_op_sel), .fpu_data(fpu_data),
      .fpu_status(fpu_status), .busy(busy), .ops_done(ops_done)
    );

    assign fpu_now = fpu_model(fpu_op_a, fpu_op_b, fpu_op_sel);
    if (LAT == 1) begin : g_comb
      assign {fpu_status, fpu_data} = fpu_now;
    end else begin : g_pipe
      logic [35:0] pipe [LAT-1];
      always_ff @(posedge clk) begin
        pipe[0] <= fpu_now;
        for (int s = 1; s < LAT - 1; s++) pipe[s] <= pipe[s-1];
      end
      assign {fpu_status, fpu_data} = pipe[LAT-2];
    end

    // Stimulus plus arbitration model: who should be granted and when.
    initial begin : drv
      logic [N-1:0] acc, exp_ready;
      logic         inflight, rst_pending, raise;
      int           due, acc_cyc, last, exp_g, cand, mode;
      logic [31:0]  ia, ib, a_tmp, b_tmp;
      logic         isel, s_tmp;
      logic [35:0]  r;
      rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
      acc = '0; inflight = 1'b0; last = N - 1; due = 0; acc_cyc = 0;
      ia = '0; ib = '0; isel = 1'b0;
      model_done = 0; last_data = '0; last_status = '0; rst_pending = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({resp_valid, busy, ops_done} != '0) begin
        bad++; $display("FAIL cfg%0d reset_ctrl: got rv=%b busy=%b ops=%0d want 0", c, resp_valid, busy, ops_done);
      end
      total++;
      if ({fpu_op_a, fpu_op_b, fpu_op_sel, resp_data, resp_status} != '0) begin
        bad++; $display("FAIL cfg%0d reset_data: got a=%h b=%h sel=%b d=%h st=%h want 0", c, fpu_op_a, fpu_op_b, fpu_op_sel, resp_data, resp_status);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      for (int step = 0; step < 600; step++) begin
        mode = (step < 20) ? 0 : (step < 80) ? 1 : (step < 580) ? 2 : 3;
        for (int i = 0; i < N; i++) if (acc[i]) req_valid[i] = 1'b0;
        acc = '0;
        if (mode == 2 && step >= 300 && rst_pending && inflight && cyc > acc_cyc && cyc < due) begin
          rst = 1'b0;
          #1;
          total++;
          if ({resp_valid, busy, ops_done} != '0) begin
            bad++; $display("FAIL cfg%0d midreset_ctrl: got rv=%b busy=%b ops=%0d want 0", c, resp_valid, busy, ops_done);
          end
          total++;
          if ({fpu_op_a, fpu_op_b, fpu_op_sel, resp_data, resp_status} != '0) begin
            bad++; $display("FAIL cfg%0d midreset_data: got a=%h d=%h st=%h want 0", c, fpu_op_a, resp_data, resp_status);
          end
          sb.delete(); inflight = 1'b0; last = N - 1; model_done = 0;
          last_data = '0; last_status = '0; req_valid = '0; rst_pending = 1'b0;
          repeat (2) @(posedge clk);
          #1 rst = 1'b1;
          for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = $urandom(); req_b[32*i +: 32] = $urandom();
            req_sel[i] = 1'($urandom_range(1)); req_valid[i] = 1'b1;
          end
        end
        for (int i = 0; i < N; i++) begin
          raise = 1'b0; a_tmp = '0; b_tmp = '0; s_tmp = 1'b0;
          if (!req_valid[i]) begin
            if (mode == 0 && step == 0 && i == 0) begin
              raise = 1'b1;
              a_tmp = (c == 0) ? 32'h3F00_0000 : 32'h3F80_0000;
              b_tmp = a_tmp;
              s_tmp = (c == 0) ? 1'b0 : 1'b1;
            end else if (mode == 1) begin
              raise = 1'b1;
              a_tmp = $urandom(); a_tmp[31:28] = 4'(i);
              b_tmp = $urandom(); s_tmp = 1'($urandom_range(1));
            end else if (mode == 2 && $urandom_range(3) == 0) begin
              raise = 1'b1;
              a_tmp = $urandom(); b_tmp = $urandom(); s_tmp = 1'($urandom_range(1));
              if ($urandom_range(7) == 0) b_tmp = a_tmp;
            end
          end
          if (raise) begin
            req_a[32*i +: 32] = a_tmp; req_b[32*i +: 32] = b_tmp;
            req_sel[i] = s_tmp; req_valid[i] = 1'b1;
          end
        end
        @(negedge clk);
        if (inflight && due == cyc) inflight = 1'b0;
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
          cand = (last + 1 + k) % N;
          if (exp_g < 0 && req_valid[cand]) exp_g = cand;
        end
        exp_ready = '0;
        if (!inflight && exp_g >= 0) exp_ready[exp_g] = 1'b1;
        total++;
        if (req_ready !== exp_ready) begin
          bad++; $display("FAIL cfg%0d ready cyc=%0d: got %b want %b", c, cyc, req_ready, exp_ready);
        end
        total++;
        if (busy !== inflight) begin
          bad++; $display("FAIL cfg%0d busy cyc=%0d: got %b want %b", c, cyc, busy, inflight);
        end
        if (inflight) begin
          total++;
          if ({fpu_op_a, fpu_op_b, fpu_op_sel} !== {ia, ib, isel}) begin
            bad++; $display("FAIL cfg%0d fpu_ops cyc=%0d: got %h %h %b want %h %h %b", c, cyc, fpu_op_a, fpu_op_b, fpu_op_sel, ia, ib, isel);
          end
        end else if (exp_g >= 0) begin
          ia = req_a[32*exp_g +: 32]; ib = req_b[32*exp_g +: 32]; isel = req_sel[exp_g];
          r = fpu_model(ia, ib, isel);
          due = cyc + LAT + 1; acc_cyc = cyc; inflight = 1'b1;
          last = exp_g; acc[exp_g] = 1'b1;
          sb.push_back('{due: due, grant: exp_g, data: r[31:0], status: r[35:32]});
        end
        @(posedge clk);
        #1;
      end
      total++;
      if (rst_pending) begin
        bad++; $display("FAIL cfg%0d reset_hit: got pending=1 want 0", c);
      end
      total++;
      if (sb.size() != 0) begin
        bad++; $display("FAIL cfg%0d drain: got %0d outstanding want 0", c, sb.size());
      end
      fin = 1'b1;
    end

    // Response monitor: every strobe must match the oldest outstanding grant.
    initial begin : mon
      exp_t         e;
      logic [N-1:0] exp_rv;
      forever begin
        @(negedge clk);
        if (rst) begin
          if (resp_valid != '0) begin
            total++;
            if (sb.size() == 0) begin
              bad++; $display("FAIL cfg%0d unexpected_resp cyc=%0d: got %b want 0", c, cyc, resp_valid);
            end else begin
              e = sb.pop_front();
              model_done++;
              exp_rv = '0; exp_rv[e.grant] = 1'b1;
              if (cyc != e.due) begin
                bad++; $display("FAIL cfg%0d resp_time: got cyc %0d want %0d", c, cyc, e.due);
              end
              total++;
              if (resp_valid !== exp_rv) begin
                bad++; $display("FAIL cfg%0d resp_valid: got %b want %b", c, resp_valid, exp_rv);
              end
              total++;
              if ({resp_status, resp_data} !== {e.status, e.data}) begin
                bad++; $display("FAIL cfg%0d resp_data: got %h/%h want %h/%h", c, resp_status, resp_data, e.status, e.data);
              end
              total++;
              if (ops_done !== CW'(model_done)) begin
                bad++; $display("FAIL cfg%0d ops_done: got %0d want %0d", c, ops_done, CW'(model_done));
              end
              last_data = e.data; last_status = e.status;
            end
          end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
              total++; bad++;
              $display("FAIL cfg%0d missing_resp cyc=%0d: got none want grant %0d", c, cyc, sb[0].grant);
              e = sb.pop_front();
            end
            total++;
            if ({resp_status, resp_data} !== {last_status, last_data}) begin
              bad++; $display("FAIL cfg%0d resp_hold cyc=%0d: got %h/%h want %h/%h", c, cyc, resp_status, resp_data, last_status, last_data);
            end
          end
        end
      end
    end
  end

  initial begin : top
    int waited;
    waited = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    total++;
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      bad++; $display("FAIL timeout: got fin=%b%b want 11", g_cfg[1].fin, g_cfg[0].fin);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
